// File: rtl/lcd_frame_pkg.sv
// rtl/lcd_frame_pkg.sv - shared types and constants for the LCD host frame parser
package lcd_frame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_AHI,
        ST_ALO,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_CLEAR,
        ST_RESP
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_CLEAR = 8'h02;
    localparam logic [7:0] CMD_PING  = 8'h03;

    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam int unsigned FB_BYTES = 504;
    localparam int          FB_AW    = 9;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_CLEAR) || (cmd == CMD_PING);
    endfunction

endpackage

// File: rtl/rx_byte_fetch.sv
// rtl/rx_byte_fetch.sv - RX FIFO pop handshake with one-cycle holdoff and inter-byte timeout
module rx_byte_fetch #(
    parameter int unsigned TMO_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       fetch_en,
    input  logic       tmo_en,
    output logic       rx_req,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       timeout
);

    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYCLES - 1);

    logic             holdoff;
    logic [TMO_W-1:0] tmo_cnt;

    // rx_ready still reflects the popped byte for one cycle after a pop, so it is masked
    assign rx_req     = fetch_en & rx_ready & ~holdoff;
    assign byte_valid = rx_req;
    assign byte_data  = rx_data;

    // a pop in the expiry cycle wins over the timeout
    assign timeout    = tmo_en & ~rx_req & (tmo_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff <= 1'b1;
            tmo_cnt <= TMO_LOAD;
        end else begin
            holdoff <= rx_req;
            if (!tmo_en || rx_req) begin
                tmo_cnt <= TMO_LOAD;
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_frame_parser.sv
// rtl/lcd_frame_parser.sv - parses host frames from the UART RX FIFO into framebuffer writes and ACK/NAK replies
module lcd_frame_parser #(
    parameter int unsigned F          = 50000000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned FB_BYTES   = 504
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_ready,
    output logic       o_rx_req,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [8:0] o_fb_addr,
    output logic [7:0] o_fb_data,
    output logic       o_fb_we,
    output logic       o_busy
);

    import lcd_frame_pkg::*;

    localparam int unsigned TMO_CYCLES = F / 1000000 * TIMEOUT_US;

    state_t     state;
    logic [7:0] cmd;
    logic [7:0] len_rem;
    logic [7:0] acc;
    logic       err;
    logic [8:0] addr;
    logic [8:0] clr_addr;

    logic       fetch_en;
    logic       tmo_en;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       timeout;

    assign fetch_en = (state != ST_CLEAR) && (state != ST_RESP);
    assign tmo_en   = fetch_en && (state != ST_IDLE);
    assign o_busy   = (state != ST_IDLE);

    rx_byte_fetch #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_fetch (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .rx_data    (i_rx_data),
        .rx_ready   (i_rx_ready),
        .fetch_en   (fetch_en),
        .tmo_en     (tmo_en),
        .rx_req     (o_rx_req),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .timeout    (timeout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cmd        <= '0;
            len_rem    <= '0;
            acc        <= '0;
            err        <= 1'b0;
            addr       <= '0;
            clr_addr   <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_fb_addr  <= '0;
            o_fb_data  <= '0;
            o_fb_we    <= 1'b0;
        end else begin
            o_fb_we    <= 1'b0;
            o_tx_valid <= 1'b0;
            if (timeout) begin
                err   <= 1'b1;
                state <= ST_RESP;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byte_valid && byte_data == SYNC_BYTE) begin
                            acc   <= '0;
                            err   <= 1'b0;
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (byte_valid) begin
                            cmd   <= byte_data;
                            acc   <= acc ^ byte_data;
                            state <= ST_AHI;
                        end
                    end
                    ST_AHI: begin
                        if (byte_valid) begin
                            addr[8] <= byte_data[0];
                            acc     <= acc ^ byte_data;
                            state   <= ST_ALO;
                        end
                    end
                    ST_ALO: begin
                        if (byte_valid) begin
                            addr[7:0] <= byte_data;
                            acc       <= acc ^ byte_data;
                            state     <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (byte_valid) begin
                            len_rem <= byte_data;
                            acc     <= acc ^ byte_data;
                            // range is checked up front so the running address can never wrap
                            if (!cmd_known(cmd) ||
                                (cmd == CMD_WRITE &&
                                 ({1'b0, addr} + {2'b00, byte_data}) > 10'(FB_BYTES))) begin
                                err <= 1'b1;
                            end
                            state <= (byte_data == 8'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (byte_valid) begin
                            acc     <= acc ^ byte_data;
                            len_rem <= len_rem - 8'd1;
                            if (cmd == CMD_WRITE && !err) begin
                                o_fb_we   <= 1'b1;
                                o_fb_addr <= addr;
                                o_fb_data <= byte_data;
                                addr      <= addr + 9'd1;
                            end
                            if (len_rem == 8'd1) begin
                                state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (byte_valid) begin
                            if (byte_data != acc) begin
                                err <= 1'b1;
                            end
                            if (cmd == CMD_CLEAR && !err && byte_data == acc) begin
                                clr_addr <= '0;
                                state    <= ST_CLEAR;
                            end else begin
                                state <= ST_RESP;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        o_fb_we   <= 1'b1;
                        o_fb_addr <= clr_addr;
                        o_fb_data <= 8'h00;
                        if (clr_addr == 9'(FB_BYTES - 1)) begin
                            state <= ST_RESP;
                        end else begin
                            clr_addr <= clr_addr + 9'd1;
                        end
                    end
                    ST_RESP: begin
                        if (i_tx_ready) begin
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= err ? NAK_BYTE : ACK_BYTE;
                            state      <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
